// File: rtl/cdf_engine_if.sv
// -----------------------------------------------------------------------------
// cdf_engine_if
// Scratch-memory port bundle used by cdf_engine: one read port (address,
// enable, data returned one cycle after RE) and one write port.
//   master : the engine side (drives addresses, enables and write data)
//   slave  : the memory side (returns ReadData1)
// Parameters:
//   ADDR_W : word address width
//   WORD_W : memory word width
// -----------------------------------------------------------------------------
interface cdf_engine_if #(
    parameter int ADDR_W = 16,
    parameter int WORD_W = 128
);
    logic [ADDR_W-1:0] ReadAddress1;
    logic              RE;
    logic [WORD_W-1:0] ReadData1;
    logic              WE;
    logic [ADDR_W-1:0] WriteAddress;
    logic [WORD_W-1:0] WriteBus;

    modport master (
        output ReadAddress1,
        output RE,
        input  ReadData1,
        output WE,
        output WriteAddress,
        output WriteBus
    );

    modport slave (
        input  ReadAddress1,
        input  RE,
        output ReadData1,
        input  WE,
        input  WriteAddress,
        input  WriteBus
    );
endinterface

// File: rtl/cdf_engine.sv
// -----------------------------------------------------------------------------
// cdf_engine
// Streams a packed histogram from scratch memory, forms a saturating running
// prefix sum over all bins and writes the packed CDF to a second region.
// One word per three cycles (read, compute, write).
//
// Optional feature macro: CDF_MIN_TRACK_EN
//   defined   : cdf_min / cdf_min_valid report the first non-zero CDF value
//   undefined : no tracking logic; cdf_min and cdf_min_valid are tied to 0
//
// Ports:
//   clk           : rising-edge clock
//   reset         : synchronous, active-low reset
//   cdf_start     : run request, sampled only while idle
//   hist_base     : word address of histogram word 0 (latched at start)
//   cdf_base      : word address of CDF word 0 (latched at start)
//   mem           : scratch-memory read/write port (cdf_engine_if.master)
//   busy          : run in progress
//   cdf_done      : one-cycle completion pulse
//   cdf_total     : unsaturated sum of all bins of the last run
//   cdf_saturated : some output lane of the last run was clipped
//   cdf_min       : first non-zero CDF value
//   cdf_min_valid : cdf_min holds a found value
//
// State table:
//   IDLE | waiting for cdf_start; bases latched and run state cleared on start
//   RD   | read request for histogram word idx
//   CALC | prefix-sum the returned word into the write buffer
//   WR   | write CDF word idx, advance idx or finish
//   DONE | completion pulse, then back to IDLE
// -----------------------------------------------------------------------------
module cdf_engine #(
    parameter int BIN_W         = 16,
    parameter int BINS_PER_WORD = 8,
    parameter int NUM_BINS      = 256,
    parameter int ADDR_W        = 16,
    parameter int SUM_W         = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cdf_start,
    input  logic [ADDR_W-1:0]    hist_base,
    input  logic [ADDR_W-1:0]    cdf_base,
    cdf_engine_if.master         mem,
    output logic                 busy,
    output logic                 cdf_done,
    output logic [SUM_W-1:0]     cdf_total,
    output logic                 cdf_saturated,
    output logic [BIN_W-1:0]     cdf_min,
    output logic                 cdf_min_valid
);

    localparam int WORD_W    = BIN_W * BINS_PER_WORD;
    localparam int NUM_WORDS = NUM_BINS / BINS_PER_WORD;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [SUM_W-1:0] BIN_MAX = {{(SUM_W-BIN_W){1'b0}}, {BIN_W{1'b1}}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CALC = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state_q;
    state_t state_next;

    logic [IDX_W-1:0]  idx_q;
    logic [ADDR_W-1:0] hist_base_q;
    logic [ADDR_W-1:0] cdf_base_q;
    logic [SUM_W-1:0]  acc_q;

    // registered copies of every output
    logic [ADDR_W-1:0] rd_addr_q;
    logic              re_q;
    logic              we_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [WORD_W-1:0] wr_bus_q;
    logic              busy_q;
    logic              done_q;
    logic [SUM_W-1:0]  total_q;
    logic              sat_q;

    logic              last_word;
    logic [SUM_W-1:0]  run_sum;
    logic [WORD_W-1:0] out_word;
    logic              any_clip;

    assign last_word = (idx_q == LAST_IDX);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE: if (cdf_start) state_next = RD;
            RD:   state_next = CALC;
            CALC: state_next = WR;
            WR:   state_next = last_word ? DONE : RD;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Lane prefix sums. The accumulator is wide enough for an all-ones
    // histogram, so run_sum never wraps; only the per-lane output clips.
    // -------------------------------------------------------------------------
    always_comb begin
        run_sum  = acc_q;
        out_word = '0;
        any_clip = 1'b0;
        for (int k = 0; k < BINS_PER_WORD; k++) begin
            run_sum = run_sum + SUM_W'(mem.ReadData1[k*BIN_W +: BIN_W]);
            if (run_sum > BIN_MAX) begin
                out_word[k*BIN_W +: BIN_W] = {BIN_W{1'b1}};
                any_clip                   = 1'b1;
            end else begin
                out_word[k*BIN_W +: BIN_W] = run_sum[BIN_W-1:0];
            end
        end
    end

`ifdef CDF_MIN_TRACK_EN
    logic [BIN_W-1:0] min_q;
    logic             min_valid_q;
    logic             min_hit;
    logic [BIN_W-1:0] min_val;

    // Lowest lane of this word with a non-zero output.
    always_comb begin
        min_hit = 1'b0;
        min_val = '0;
        for (int k = 0; k < BINS_PER_WORD; k++) begin
            if (!min_hit && (out_word[k*BIN_W +: BIN_W] != '0)) begin
                min_hit = 1'b1;
                min_val = out_word[k*BIN_W +: BIN_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            min_q       <= '0;
            min_valid_q <= 1'b0;
        end else if (state_q == IDLE && cdf_start) begin
            min_q       <= '0;
            min_valid_q <= 1'b0;
        end else if (state_q == CALC && !min_valid_q && min_hit) begin
            min_q       <= min_val;
            min_valid_q <= 1'b1;
        end
    end

    assign cdf_min       = min_q;
    assign cdf_min_valid = min_valid_q;
`else
    assign cdf_min       = '0;
    assign cdf_min_valid = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // State, datapath and registered outputs. Strobes are registered from
    // state_next so they line up with the state they belong to.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            hist_base_q <= '0;
            cdf_base_q  <= '0;
            acc_q       <= '0;
            rd_addr_q   <= '0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            wr_addr_q   <= '0;
            wr_bus_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            total_q     <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q <= state_next;
            re_q    <= (state_next == RD);
            we_q    <= (state_next == WR);
            busy_q  <= (state_next == RD) || (state_next == CALC) || (state_next == WR);
            done_q  <= (state_next == DONE);

            case (state_q)
                IDLE: begin
                    if (cdf_start) begin
                        hist_base_q <= hist_base;
                        cdf_base_q  <= cdf_base;
                        acc_q       <= '0;
                        idx_q       <= '0;
                        sat_q       <= 1'b0;
                        rd_addr_q   <= hist_base;
                    end
                end
                CALC: begin
                    acc_q     <= run_sum;
                    wr_bus_q  <= out_word;
                    wr_addr_q <= cdf_base_q + ADDR_W'(idx_q);
                    if (any_clip) sat_q <= 1'b1;
                end
                WR: begin
                    if (last_word) begin
                        // total is published together with the done pulse
                        total_q <= acc_q;
                    end else begin
                        idx_q     <= idx_q + IDX_W'(1);
                        rd_addr_q <= hist_base_q + ADDR_W'(idx_q) + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem.ReadAddress1 = rd_addr_q;
    assign mem.RE           = re_q;
    assign mem.WE           = we_q;
    assign mem.WriteAddress = wr_addr_q;
    assign mem.WriteBus     = wr_bus_q;
    assign busy             = busy_q;
    assign cdf_done         = done_q;
    assign cdf_total        = total_q;
    assign cdf_saturated    = sat_q;

endmodule
